// File: rtl/serial_parallel_pkg.sv
// Shared state encodings for the serial-to-parallel receiver.
package serial_parallel_pkg;

    // Receive side: IDLE means no partial word is held (bit count is zero).
    typedef enum logic {
        RX_IDLE,
        RX_SHIFT
    } rx_state_t;

    // One-entry output holding register.
    typedef enum logic {
        BUF_EMPTY,
        BUF_FULL
    } buf_state_t;

endpackage

// File: rtl/sp_out_buffer.sv
// One-entry valid/ready holding register for completed words. A word that
// completes while the entry is occupied and not being drained is dropped
// and reported with a single-cycle overrun pulse.
module sp_out_buffer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] word_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             overrun_o
);
    import serial_parallel_pkg::*;

    buf_state_t       state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             overrun_q, overrun_d;

    // Next-state: load when empty, swap on same-cycle drain, otherwise drop.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        overrun_d = 1'b0;
        case (state_q)
            BUF_EMPTY: begin
                if (load_i) begin
                    data_d  = word_i;
                    state_d = BUF_FULL;
                end
            end
            BUF_FULL: begin
                if (ready_i) begin
                    // Old word leaves this cycle; a new one may replace it
                    // without a bubble. data_q is kept when going empty.
                    if (load_i) begin
                        data_d = word_i;
                    end else begin
                        state_d = BUF_EMPTY;
                    end
                end else if (load_i) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
    end

    // State, data and pulse registers; reset clears everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= BUF_EMPTY;
            data_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            overrun_q <= overrun_d;
        end
    end

    assign data_o    = data_q;
    assign valid_o   = (state_q == BUF_FULL);
    assign overrun_o = overrun_q;

endmodule

// File: rtl/serial_parallel.sv
// Serial-to-parallel receiver for the LSB-first serial link. Shifts in one
// qualified bit per clock, hands each completed WIDTH-bit word to a
// one-entry output buffer and flags mid-word gaps as frame errors.
module serial_parallel #(
    parameter int WIDTH        = 4,
    parameter bit ABORT_ON_GAP = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             serial_i,
    input  logic             valid_i,
    output logic [WIDTH-1:0] parallel_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             busy_o,
    output logic             frame_err_o,
    output logic             overrun_o
);
    import serial_parallel_pkg::*;

    localparam int CW = $clog2(WIDTH + 1);

    rx_state_t        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // Only the upper WIDTH-1 bits of the conceptual shift register are ever
    // read back: the bit that would fall off the bottom is never needed, so
    // it is not stored. The completed word is {serial_i, shreg_q}.
    logic [WIDTH-2:0] shreg_q, shreg_d;
    logic             frame_err_q, frame_err_d;
    logic [WIDTH-1:0] shifted;
    logic             complete;

    // Receive FSM: shift accepted bits, detect completion and gaps.
    always_comb begin
        shifted     = {serial_i, shreg_q};
        complete    = valid_i && (cnt_q == CW'(WIDTH - 1));
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        frame_err_d = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (valid_i) begin
                    shreg_d = shifted[WIDTH-1:1];
                    cnt_d   = CW'(1);
                    state_d = RX_SHIFT;
                end
            end
            RX_SHIFT: begin
                if (valid_i) begin
                    shreg_d = shifted[WIDTH-1:1];
                    if (complete) begin
                        cnt_d   = '0;
                        state_d = RX_IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (ABORT_ON_GAP) begin
                    // Partial word is discarded; stale shreg bits are
                    // overwritten by the next WIDTH accepted bits.
                    cnt_d       = '0;
                    state_d     = RX_IDLE;
                    frame_err_d = 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = RX_IDLE;
            end
        endcase
    end

    // Receive-side registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RX_IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            frame_err_q <= frame_err_d;
        end
    end

    sp_out_buffer #(
        .WIDTH(WIDTH)
    ) u_out_buffer (
        .clk      (clk),
        .reset    (reset),
        .load_i   (complete),
        .word_i   (shifted),
        .ready_i  (out_ready_i),
        .data_o   (parallel_o),
        .valid_o  (out_valid_o),
        .overrun_o(overrun_o)
    );

    assign busy_o      = (state_q == RX_SHIFT);
    assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_serial_parallel.sv
// Bench for serial_parallel: two instances (abort-on-gap and hold-on-gap)
// share the same stimulus; a bit-level reference model predicts buffer
// contents and pulses, and a queue holds the words the consumer must see.
module tb_serial_parallel;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       serial_i, valid_i, out_ready_i;
    logic [3:0] par  [2];
    logic       ov   [2];
    logic       busy [2];
    logic       ferr [2];
    logic       ovr  [2];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, index 0 = abort on gap, 1 = hold on gap.
    int         m_cnt  [2];
    logic [3:0] m_acc  [2];
    logic [3:0] m_data [2];
    bit         m_full [2];
    bit         e_ferr [2];
    bit         e_ovr  [2];
    bit         abort_of [2] = '{1'b1, 1'b0};
    logic [3:0] q_a[$];
    logic [3:0] q_h[$];

    always #5 clk = ~clk;

    serial_parallel #(.WIDTH(4), .ABORT_ON_GAP(1'b1)) dut_a (
        .clk(clk), .reset(rst_n), .serial_i(serial_i), .valid_i(valid_i),
        .parallel_o(par[0]), .out_valid_o(ov[0]), .out_ready_i(out_ready_i),
        .busy_o(busy[0]), .frame_err_o(ferr[0]), .overrun_o(ovr[0])
    );

    serial_parallel #(.WIDTH(4), .ABORT_ON_GAP(1'b0)) dut_h (
        .clk(clk), .reset(rst_n), .serial_i(serial_i), .valid_i(valid_i),
        .parallel_o(par[1]), .out_valid_o(ov[1]), .out_ready_i(out_ready_i),
        .busy_o(busy[1]), .frame_err_o(ferr[1]), .overrun_o(ovr[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic string tg(input string s, input int i);
        return $sformatf("%s[%0d]", s, i);
    endfunction

    task automatic sb_push(input int i, input logic [3:0] w);
        if (i == 0) q_a.push_back(w);
        else        q_h.push_back(w);
    endtask

    // Consumer takes a word: it must be the oldest one the model loaded.
    task automatic sb_pop(input int i);
        logic [3:0] e;
        bit         has;
        e   = '0;
        has = (i == 0) ? (q_a.size() > 0) : (q_h.size() > 0);
        if (!has) begin
            check(tg("sb_unexpected_word", i), 32'd1, 32'd0);
        end else begin
            e = (i == 0) ? q_a.pop_front() : q_h.pop_front();
            check(tg("sb_word", i), par[i], e);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_acc[i] = '0; m_data[i] = '0;
            m_full[i] = 0; e_ferr[i] = 0; e_ovr[i] = 0;
        end
        q_a.delete();
        q_h.delete();
    endtask

    task automatic model_step(input int i, input bit v, input bit s, input bit r);
        bit hs;
        bit done;
        hs   = m_full[i] && r;
        done = 0;
        e_ferr[i] = 0;
        e_ovr[i]  = 0;
        if (v) begin
            m_acc[i][m_cnt[i]] = s;
            m_cnt[i]++;
            if (m_cnt[i] == 4) done = 1;
        end else if (m_cnt[i] != 0 && abort_of[i]) begin
            m_cnt[i]  = 0;
            e_ferr[i] = 1;
        end
        if (done) begin
            if (!m_full[i] || r) begin
                m_full[i] = 1;
                m_data[i] = m_acc[i];
                sb_push(i, m_acc[i]);
            end else begin
                e_ovr[i] = 1;
            end
            m_cnt[i] = 0;
            m_acc[i] = '0;
        end else if (hs) begin
            m_full[i] = 0;
        end
    endtask

    // One clock: drive inputs, retire handshakes, step model, compare.
    task automatic tick(input bit v, input bit s, input bit r);
        valid_i = v; serial_i = s; out_ready_i = r;
        for (int i = 0; i < 2; i++) if (ov[i] && r) sb_pop(i);
        for (int i = 0; i < 2; i++) model_step(i, v, s, r);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check(tg("out_valid", i), ov[i],   m_full[i]);
            check(tg("busy", i),      busy[i], m_cnt[i] != 0);
            check(tg("frame_err", i), ferr[i], e_ferr[i]);
            check(tg("overrun", i),   ovr[i],  e_ovr[i]);
            check(tg("parallel", i),  par[i],  m_data[i]);
        end
    endtask

    task automatic send(input logic [3:0] w, input bit r);
        for (int b = 0; b < 4; b++) tick(1'b1, w[b], r);
    endtask

    task automatic check_all_zero(input string s);
        for (int i = 0; i < 2; i++) begin
            check(tg({s, "_par"}, i),  par[i],  32'd0);
            check(tg({s, "_ov"}, i),   ov[i],   32'd0);
            check(tg({s, "_busy"}, i), busy[i], 32'd0);
            check(tg({s, "_ferr"}, i), ferr[i], 32'd0);
            check(tg({s, "_ovr"}, i),  ovr[i],  32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; valid_i = 1'b0; serial_i = 1'b0; out_ready_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        tick(0, 0, 0);

        // Single word 1,0,1,1 held until accepted.
        send(4'hD, 0);
        check("tp1_word", par[0], 32'hD);
        check("tp1_valid", ov[0], 32'd1);
        check("tp1_busy", busy[0], 32'd0);
        tick(0, 0, 0);
        tick(0, 0, 0);
        check("tp1_hold", par[0], 32'hD);
        tick(0, 0, 1);
        check("tp1_drained", ov[0], 32'd0);

        // Back-to-back words with a ready consumer.
        send(4'h9, 1);
        check("tp2_first", par[0], 32'h9);
        send(4'h6, 1);
        check("tp2_second", par[0], 32'h6);
        check("tp2_no_overrun", ovr[0], 32'd0);
        tick(0, 0, 1);

        // Overrun: second word arrives while first is still held.
        send(4'h3, 0);
        send(4'hC, 0);
        check("tp3_overrun", ovr[0], 32'd1);
        check("tp3_kept", par[0], 32'h3);
        tick(0, 0, 1);
        send(4'h5, 0);
        check("tp3_after", par[0], 32'h5);
        tick(0, 0, 1);

        // Gap after two bits.
        tick(1, 1, 1);
        tick(1, 1, 1);
        tick(0, 0, 1);
        check("tp4_ferr_abort", ferr[0], 32'd1);
        check("tp4_ferr_hold", ferr[1], 32'd0);
        check("tp4_busy_abort", busy[0], 32'd0);
        tick(1, 0, 1);
        tick(1, 1, 1);
        check("tp4_hold_word", par[1], 32'hB);
        tick(1, 0, 1);
        tick(1, 1, 1);
        check("tp4_abort_word", par[0], 32'hA);
        check("tp4_busy_hold", busy[1], 32'd1);
        tick(0, 0, 1);

        // Asynchronous reset with buffer full and a partial word in flight.
        send(4'h7, 0);
        tick(1, 1, 0);
        tick(1, 1, 0);
        tick(1, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(0, 0, 0);
        send(4'hF, 0);
        check("tp5_fresh", par[0], 32'hF);
        check("tp5_fresh_h", par[1], 32'hF);
        tick(0, 0, 1);

        // Completion and drain on the same edge while full.
        send(4'h2, 0);
        tick(1, 0, 0);
        tick(1, 0, 0);
        tick(1, 0, 0);
        tick(1, 1, 1);
        check("tp6_valid", ov[0], 32'd1);
        check("tp6_word", par[0], 32'h8);
        check("tp6_no_overrun", ovr[0], 32'd0);
        tick(0, 0, 1);

        // Random traffic.
        for (int n = 0; n < 300; n++) begin
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 2) != 0);
        end
        tick(0, 0, 1);
        tick(0, 0, 1);
        check("sb_empty_a", q_a.size(), 32'd0);
        check("sb_empty_h", q_h.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_parallel.md
Name: serial_parallel

Overview:
Serial-to-parallel receiver, the receive end of the team's 4-bit LSB-first serial link. Accepts one qualified bit per clock (serial_i/valid_i), assembles WIDTH-bit words and presents each completed word on a one-entry valid/ready output buffer. Detects mid-word gaps (frame error) and words lost to a full buffer (overrun). Sits between the serial link pins/loopback and the parallel consumer logic.

Parameters:
WIDTH, 4, word width in bits; legal range 2..32.
ABORT_ON_GAP, 1, 1 = valid_i low mid-word discards the partial word; 0 = gap holds the partial word.

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
serial_i  input  1  serial data bit, LSB of word first
valid_i  input  1  serial_i is a valid bit this cycle
parallel_o  output  WIDTH  assembled word, stable while out_valid_o=1
out_valid_o  output  1  output buffer holds a word
out_ready_i  input  1  consumer accepts word this cycle
busy_o  output  1  partial word in progress (bit count != 0)
frame_err_o  output  1  one-cycle pulse: partial word aborted by gap
overrun_o  output  1  one-cycle pulse: completed word dropped, buffer full

Behaviour:
- Reset (reset=0, async): bit count=0, shift reg=0, parallel_o=0, out_valid_o=0, busy_o=0, frame_err_o=0, overrun_o=0. Reset mid-word discards partial word and buffered word; no pulses on release.
- Bit count width $clog2(WIDTH+1); counts accepted bits 0..WIDTH-1.
- Accept: valid_i=1 -> shreg <= {serial_i, shreg[WIDTH-1:1]}, count+1. First received bit lands in parallel bit 0.
- Completion: valid_i=1 with count==WIDTH-1 -> word = {serial_i, shreg[WIDTH-1:1]}; count -> 0 on same edge. Word visible on parallel_o with out_valid_o=1 on the edge that samples the last bit (latency 1 clock from last bit's cycle).
- Receive FSM: IDLE (count=0) -> SHIFT on first valid bit; SHIFT -> IDLE on completion or abort. busy_o = (state==SHIFT).
- Gap (valid_i=0 in SHIFT): ABORT_ON_GAP=1 -> count=0, state IDLE, frame_err_o=1 next cycle for one cycle. ABORT_ON_GAP=0 -> hold count and shreg, no error.
- Output buffer FSM: EMPTY / FULL. out_valid_o = FULL. Handshake completes when out_valid_o & out_ready_i; parallel_o must not change while FULL and not accepted.
- Completion while EMPTY -> load, FULL.
- Completion while FULL and out_ready_i=1 same cycle -> old word consumed, new word loaded, stays FULL (back-to-back, no bubble).
- Completion while FULL and out_ready_i=0 -> new word dropped, buffer keeps old word, overrun_o=1 for one cycle, count -> 0.
- Handshake with no completion -> EMPTY. parallel_o retains last value when EMPTY (do not clear).
- Sustained valid_i=1 yields one word every WIDTH clocks with no lost bits while consumer keeps out_ready_i=1.
- frame_err_o and overrun_o registered, never asserted together (mutually exclusive causes).

Decomposition:
- serial_parallel_pkg: rx_state_t {RX_IDLE, RX_SHIFT}, buf_state_t {BUF_EMPTY, BUF_FULL}.
- One sub-module natural: sp_out_buffer (one-entry valid/ready holding register with overrun pulse, parameterised by WIDTH); serial_parallel instantiates it and holds shift/count/FSM logic.

Test Plan:
- WIDTH=4, valid_i=1 for 4 cycles, serial_i=1,0,1,1, out_ready_i=0 -> after 4th edge out_valid_o=1, parallel_o=4'hD, busy_o=0; holds until out_ready_i=1, then out_valid_o=0.
- Back-to-back 4'h9 then 4'h6 (8 continuous valid bits), out_ready_i=1 -> out_valid_o high edges 4..8, parallel_o=4'h9 then 4'h6, no overrun_o.
- Buffer FULL (4'h3, out_ready_i=0), send 4'hC -> overrun_o one-cycle pulse, parallel_o stays 4'h3; subsequent 4'h5 after accept received correctly.
- ABORT_ON_GAP=1: 2 bits, valid_i=0 one cycle, then 4 bits of 4'hA -> frame_err_o pulse, busy_o 0 after gap, parallel_o=4'hA; ABORT_ON_GAP=0 same stimulus with 2 bits resuming -> word completes from 2+2 bits, no error.
- Assert reset (0) after 3 bits and while buffer FULL -> all outputs 0 immediately (async); after release a fresh 4'hF received cleanly.
- Completion and out_ready_i=1 in same cycle with buffer FULL -> out_valid_o stays 1, parallel_o switches to new word, overrun_o stays 0.
